sdf_butterfly: RTL and testbench

Radix-2 single-path delay-feedback (SDF) butterfly stage for the FFT pipeline. It accepts a gapped stream of complex samples and pairs each sample with the one received M valid samples earlier, using an internal feedback delay line. It emits a scaled sum immediately and recirculates the scaled difference for output during the next half-frame. One instance is placed per FFT stage, and the stage span M halves at each successive stage.

---
 rtl/sdf_butterfly.sv | 102 ++++++++++
 tb/tb_sdf_butterfly.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage: pairs each sample with the one
// received M valid samples earlier, emits the scaled sum, recirculates the scaled difference.
module sdf_butterfly #(
  parameter int M     = 32,
  parameter int WIDTH = 16,
  parameter int SCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int CW = $clog2(2 * M);
  localparam logic [CW-1:0] C_LAST = '1;
  localparam logic [CW-1:0] C_HALF_M1 = CW'(M - 1);
  localparam logic signed [WIDTH+1:0] C_ONE = (WIDTH + 2)'(1);

  // Raw sum/difference arrives in WIDTH+1 bits; two guard bits keep the +1 rounding exact.
  function automatic logic signed [WIDTH-1:0] scale_sat(input logic signed [WIDTH:0] r);
    logic signed [WIDTH+1:0] t;
    t = $signed({r[WIDTH], r});
    if (SCALE != 0) begin
      t = t + C_ONE;
      t = t >>> 1;
    end
    if (t[WIDTH+1:WIDTH-1] != {3{t[WIDTH+1]}}) begin
      scale_sat = t[WIDTH+1] ? $signed({1'b1, {(WIDTH-1){1'b0}}})
                             : $signed({1'b0, {(WIDTH-1){1'b1}}});
    end else begin
      scale_sat = t[WIDTH-1:0];
    end
  endfunction

  logic [CW-1:0]           r_cnt;
  logic                    r_pend;
  logic signed [WIDTH-1:0] r_dl_re [M];
  logic signed [WIDTH-1:0] r_dl_im [M];

  logic                    w_fill;
  logic signed [WIDTH:0]   w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [WIDTH-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  assign w_fill   = ~r_cnt[CW-1];
  assign w_a_re   = $signed({r_dl_re[M-1][WIDTH-1], r_dl_re[M-1]});
  assign w_a_im   = $signed({r_dl_im[M-1][WIDTH-1], r_dl_im[M-1]});
  assign w_b_re   = $signed({di_re[WIDTH-1], di_re});
  assign w_b_im   = $signed({di_im[WIDTH-1], di_im});
  assign w_sum_re = scale_sat(w_a_re + w_b_re);
  assign w_sum_im = scale_sat(w_a_im + w_b_im);
  assign w_dif_re = scale_sat(w_a_re - w_b_re);
  assign w_dif_im = scale_sat(w_a_im - w_b_im);

  // Single registered stage: counter, delay line and output all advance on di_en.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
      for (int i = 0; i < M; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else begin
      do_en <= 1'b0;
      if (di_en) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == C_LAST) begin
          r_pend <= 1'b1;
        end else if (r_cnt == C_HALF_M1) begin
          r_pend <= 1'b0;
        end
        for (int i = 1; i < M; i++) begin
          r_dl_re[i] <= r_dl_re[i-1];
          r_dl_im[i] <= r_dl_im[i-1];
        end
        if (w_fill) begin
          r_dl_re[0] <= di_re;
          r_dl_im[0] <= di_im;
          if (r_pend) begin
            do_en <= 1'b1;
            do_re <= r_dl_re[M-1];
            do_im <= r_dl_im[M-1];
          end
        end else begin
          r_dl_re[0] <= w_dif_re;
          r_dl_im[0] <= w_dif_im;
          do_en      <= 1'b1;
          do_re      <= w_sum_re;
          do_im      <= w_sum_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdf_butterfly.sv
// Directed bench for sdf_butterfly: M=4 scaled, M=1 scaled and M=1 saturating instances
// share one stimulus stream; each sample's output is checked one cycle after it is driven.
module tb_sdf_butterfly;

  logic        clock = 1'b0;
  logic        reset;
  logic        di_en;
  logic [15:0] di_re, di_im;

  logic        e4, e1s, e1n;
  logic [15:0] r4, i4, r1s, i1s, r1n, i1n;

  int n_chk = 0;
  int n_err = 0;
  int xr[84];
  int xi[84];

  always #5 clock = ~clock;

  sdf_butterfly #(.M(4), .WIDTH(16), .SCALE(1)) u_m4 (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(e4), .do_re(r4), .do_im(i4));
  sdf_butterfly #(.M(1), .WIDTH(16), .SCALE(1)) u_m1s (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(e1s), .do_re(r1s), .do_im(i1s));
  sdf_butterfly #(.M(1), .WIDTH(16), .SCALE(0)) u_m1n (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(e1n), .do_re(r1n), .do_im(i1n));

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input bit en, input int re, input int im);
    di_en = en;
    di_re = 16'(re);
    di_im = 16'(im);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step(1'b1, 999, 999);
    check("rst_pri_en", int'(e4), 0);
    reset = 1'b0;
  endtask

  function automatic int bscale(input int r);
    int t;
    t = (r + 1) >>> 1;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  // Frame-indexed reference for M=4: sums at positions M..2M-1, differences one frame later.
  task automatic model(input int k, output bit en, output int er, output int ei);
    int c, f, base;
    c = k % 8;
    f = k / 8;
    en = 1'b0; er = 0; ei = 0;
    if (c >= 4) begin
      en = 1'b1;
      er = bscale(xr[k-4] + xr[k]);
      ei = bscale(xi[k-4] + xi[k]);
    end else if (f > 0) begin
      base = (f - 1) * 8 + c;
      en = 1'b1;
      er = bscale(xr[base] - xr[base+4]);
      ei = bscale(xi[base] - xi[base+4]);
    end
  endtask

  task automatic run_basic(input bit gap, input string tag);
    int last, exp;
    last = 0;
    reset_pulse();
    for (int k = 0; k < 12; k++) begin
      if (gap) begin
        repeat (2) begin
          step(1'b0, 0, 0);
          check({tag, "_idle_en"}, int'(e4), 0);
          check({tag, "_hold_re"}, int'($signed(r4)), last);
        end
      end
      step(1'b1, (k < 8) ? k + 1 : 0, 0);
      if (k < 4) begin
        check({tag, "_fill_en"}, int'(e4), 0);
      end else begin
        exp = (k < 8) ? k - 1 : -2;
        check({tag, "_en"}, int'(e4), 1);
        check({tag, "_re"}, int'($signed(r4)), exp);
        check({tag, "_im"}, int'($signed(i4)), 0);
        last = exp;
      end
    end
  endtask

  initial begin
    bit en;
    int er, ei;
    reset = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;

    for (int i = 0; i < 3; i++) begin
      step(1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      check("rst_en", int'(e4), 0);
      check("rst_re", int'(r4), 0);
      check("rst_im", int'(i4), 0);
      check("rst_en_m1", int'(e1s), 0);
    end
    reset = 1'b0;
    step(1'b1, 5, 7);
    check("rel_en", int'(e4), 0);
    check("rel_re", int'(r4), 0);
    check("rel_im", int'(i4), 0);

    run_basic(1'b0, "basic");
    run_basic(1'b1, "gap");

    reset_pulse();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 100 + i, -i);
      check("mid_pre_en", int'(e4), (i >= 4) ? 1 : 0);
    end
    run_basic(1'b0, "midrst");

    reset_pulse();
    step(1'b1, 32767, -32768);
    check("sat1_a_en", int'(e1s), 0);
    check("sat0_a_en", int'(e1n), 0);
    step(1'b1, -32768, 32767);
    check("sat1_sum_en", int'(e1s), 1);
    check("sat1_sum_re", int'($signed(r1s)), 0);
    check("sat1_sum_im", int'($signed(i1s)), 0);
    check("sat0_sum_re", int'($signed(r1n)), -1);
    check("sat0_sum_im", int'($signed(i1n)), -1);
    step(1'b1, 0, 0);
    check("sat1_dif_en", int'(e1s), 1);
    check("sat1_dif_re", int'($signed(r1s)), 32767);
    check("sat1_dif_im", int'($signed(i1s)), -32767);
    check("sat0_dif_re", int'($signed(r1n)), 32767);
    check("sat0_dif_im", int'($signed(i1n)), -32768);

    reset_pulse();
    step(1'b1, 20000, 0);
    check("sat0_b_en", int'(e1n), 0);
    step(1'b1, 20000, 0);
    check("sat0_b_en2", int'(e1n), 1);
    check("sat0_b_re", int'($signed(r1n)), 32767);
    check("sat0_b_im", int'($signed(i1n)), 0);
    check("sat1_b_re", int'($signed(r1s)), 20000);
    step(1'b1, 0, 0);
    check("sat0_b_dif", int'($signed(r1n)), 0);

    for (int k = 0; k < 84; k++) begin
      logic [15:0] tr, ti;
      tr = 16'($urandom);
      ti = 16'($urandom);
      xr[k] = (k < 80) ? int'($signed(tr)) : 0;
      xi[k] = (k < 80) ? int'($signed(ti)) : 0;
    end
    reset_pulse();
    for (int k = 0; k < 84; k++) begin
      step(1'b1, xr[k], xi[k]);
      model(k, en, er, ei);
      check("cont_en", int'(e4), int'(en));
      if (en) begin
        check("cont_re", int'($signed(r4)), er);
        check("cont_im", int'($signed(i4)), ei);
      end
    end
    step(1'b0, 0, 0);
    check("cont_tail_en", int'(e4), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
